// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared types and the output round/saturate helper for the
//                multi-channel FIR MAC engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    // Control states shared by all lanes
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } fir_state_t;

    // Result of the output conversion: clip flag plus value, sign-extended
    typedef struct packed {
        logic               sat;
        logic signed [63:0] val;
    } rs_t;

    // Optional round-half-up, arithmetic shift, then clip to a signed
    // out_w-bit range. The accumulator is presented sign-extended to 64 bits.
    function automatic rs_t round_sat(input logic signed [63:0] acc,
                                      input int                 shift,
                                      input bit                 rnd,
                                      input int                 out_w);
        rs_t                r;
        logic signed [63:0] t;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        t = acc;
        if (rnd && (shift > 0)) begin
            t = t + (64'sd1 <<< (shift - 1));
        end
        t  = t >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        r.sat = 1'b0;
        r.val = t;
        if (t > hi) begin
            r.sat = 1'b1;
            r.val = hi;
        end else if (t < lo) begin
            r.sat = 1'b1;
            r.val = lo;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_mac_lane.sv
`default_nettype none
// ============================================================================
//  Module      : fir_mac_lane
//  Description : One FIR channel: signed accumulator plus registered
//                round/shift/saturate output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_mac_lane
    import fir_pkg::*;
#(
    parameter int SMPL_W    = 16,
    parameter int CFF_W     = 16,
    parameter int ACC_W     = 42,
    parameter int OUT_SHIFT = 15,
    parameter int RND       = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     mac_en_i,
    input  logic                     cap_en_i,
    input  logic signed [SMPL_W-1:0] smpl_i,
    input  logic signed [CFF_W-1:0]  cff_i,
    output logic signed [SMPL_W-1:0] smpl_o,
    output logic                     sat_o
);

    localparam int PROD_W = SMPL_W + CFF_W;

    logic signed [PROD_W-1:0] prod_w;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [63:0]       acc64_w;
    rs_t                      rs_w;
    logic                     unused_hi;

    assign prod_w  = smpl_i * cff_i;
    assign acc64_w = {{(64 - ACC_W){acc_q[ACC_W-1]}}, acc_q};
    assign rs_w    = round_sat(acc64_w, OUT_SHIFT, (RND != 0), SMPL_W);
    // Clipped value always fits SMPL_W; upper bits are pure sign extension
    assign unused_hi = ^rs_w.val[63:SMPL_W];

    // Next accumulator: clear at pass start, add the sign-extended product per tap
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (mac_en_i) begin
            acc_d = acc_q + {{(ACC_W - PROD_W){prod_w[PROD_W-1]}}, prod_w};
        end
    end

    // Accumulator register and output capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            smpl_o <= '0;
            sat_o  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            if (cap_en_i) begin
                smpl_o <= rs_w.val[SMPL_W-1:0];
                sat_o  <= rs_w.sat;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_mac_multi.sv
`default_nettype none
// ============================================================================
//  Module      : fir_mac_multi
//  Description : Multi-channel FIR MAC engine. One shared control FSM walks
//                the coefficient index; NUM_CH lanes accumulate in parallel.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_mac_multi
    import fir_pkg::*;
#(
    parameter int NUM_COEFF = 1021,
    parameter int NUM_CH    = 2,
    parameter int SMPL_W    = 16,
    parameter int CFF_W     = 16,
    parameter int OUT_SHIFT = 15,
    parameter int RND       = 1,
    localparam int PTR_W    = $clog2(NUM_COEFF + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       tap_vld,
    input  logic [NUM_CH*SMPL_W-1:0]   smpl_in,
    input  logic [CFF_W-1:0]           cff_in,
    output logic [PTR_W-1:0]           cff_ptr,
    output logic [NUM_CH*SMPL_W-1:0]   smpl_out,
    output logic [NUM_CH-1:0]          sat,
    output logic                       busy,
    output logic                       done
);

    localparam int ACC_W = SMPL_W + CFF_W + $clog2(NUM_COEFF);

    fir_state_t       state_q;
    logic [PTR_W-1:0] ptr_q;
    logic             done_q;
    logic             clr_w;
    logic             mac_en_w;
    logic             cap_en_w;

    assign clr_w    = (state_q == ST_IDLE) && start && !abort;
    assign mac_en_w = (state_q == ST_MAC) && tap_vld && !abort;
    assign cap_en_w = (state_q == ST_DONE) && !abort;

    assign cff_ptr = ptr_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;

    // Shared control: state, coefficient index and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ptr_q <= '0;
                    if (start && !abort) begin
                        state_q <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        ptr_q   <= '0;
                    end else if (tap_vld) begin
                        ptr_q <= ptr_q + PTR_W'(1);
                        if (ptr_q == PTR_W'(NUM_COEFF - 1)) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    ptr_q   <= '0;
                    done_q  <= !abort;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
            fir_mac_lane #(
                .SMPL_W    (SMPL_W),
                .CFF_W     (CFF_W),
                .ACC_W     (ACC_W),
                .OUT_SHIFT (OUT_SHIFT),
                .RND       (RND)
            ) u_lane (
                .clk      (clk),
                .rst_n    (rst_n),
                .clr_i    (clr_w),
                .mac_en_i (mac_en_w),
                .cap_en_i (cap_en_w),
                .smpl_i   (smpl_in[c*SMPL_W +: SMPL_W]),
                .cff_i    (cff_in),
                .smpl_o   (smpl_out[c*SMPL_W +: SMPL_W]),
                .sat_o    (sat[c])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_mac_multi
//  Description : Self-checking bench for fir_mac_multi (NUM_COEFF=4, NUM_CH=2)
//                with a rounding and a truncating instance side by side.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_mac_multi;

    localparam int NC = 4;
    localparam int PW = $clog2(NC + 1);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        tap_vld = 1'b0;
    logic [31:0] smpl_in_r, smpl_in_t, out_r, out_t;
    logic [15:0] cff_in_r, cff_in_t;
    logic [PW-1:0] ptr_r, ptr_t;
    logic [1:0]  sat_r, sat_t;
    logic        busy_r, busy_t, done_r, done_t;

    logic signed [15:0] rom [0:NC-1];
    logic signed [15:0] smp [0:1][0:NC-1];

    int n_tests = 0;
    int n_fail  = 0;
    logic [16:0] exp_r0, exp_r1, exp_t0, exp_t1;

    always #5 clk = ~clk;

    // Combinational coefficient ROM and per-tap sample source for each instance
    assign cff_in_r  = (ptr_r < PW'(NC)) ? rom[ptr_r[1:0]] : 16'h0;
    assign cff_in_t  = (ptr_t < PW'(NC)) ? rom[ptr_t[1:0]] : 16'h0;
    assign smpl_in_r = (ptr_r < PW'(NC)) ? {smp[1][ptr_r[1:0]], smp[0][ptr_r[1:0]]} : 32'h0;
    assign smpl_in_t = (ptr_t < PW'(NC)) ? {smp[1][ptr_t[1:0]], smp[0][ptr_t[1:0]]} : 32'h0;

    fir_mac_multi #(.NUM_COEFF(NC), .NUM_CH(2), .RND(1)) dut_r (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .tap_vld(tap_vld),
        .smpl_in(smpl_in_r), .cff_in(cff_in_r), .cff_ptr(ptr_r), .smpl_out(out_r),
        .sat(sat_r), .busy(busy_r), .done(done_r));

    fir_mac_multi #(.NUM_COEFF(NC), .NUM_CH(2), .RND(0)) dut_t (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .tap_vld(tap_vld),
        .smpl_in(smpl_in_t), .cff_in(cff_in_t), .cff_ptr(ptr_t), .smpl_out(out_t),
        .sat(sat_t), .busy(busy_t), .done(done_t));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: dot product, optional +half, floor-divide by 2^15, clip. {sat, value}
    function automatic logic [16:0] model(input int ch, input bit rnd);
        longint acc;
        acc = 0;
        for (int k = 0; k < NC; k++) acc += longint'(rom[k]) * longint'(smp[ch][k]);
        if (rnd) acc += 64'sd16384;
        acc = acc >>> 15;
        if (acc > 32767)       return {1'b1, 16'h7FFF};
        else if (acc < -32768) return {1'b1, 16'h8000};
        else                   return {1'b0, acc[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] c0, c1, c2, c3, input logic [15:0] s0, s1);
        rom[0] = c0; rom[1] = c1; rom[2] = c2; rom[3] = c3;
        for (int k = 0; k < NC; k++) begin smp[0][k] = s0; smp[1][k] = s1; end
    endtask

    task automatic load_rand();
        for (int k = 0; k < NC; k++) begin
            rom[k]    = 16'($urandom);
            smp[0][k] = 16'($urandom);
            smp[1][k] = 16'($urandom);
        end
    endtask

    // One pass; stall of stall_len cycles begins in cycle 3 (after tap 2).
    task automatic run_pass(input string tag, input int stall_len, input bit mid_start);
        int c;
        start = 1'b1; tap_vld = 1'b1;
        tick();
        c = 1;
        start = 1'b0;
        while (c < 40 && !done_r) begin
            tap_vld = !(c >= 3 && c < 3 + stall_len);
            start   = mid_start && (c == 2);
            if (!tap_vld) chk({tag, "_stall_ptr"}, 64'(ptr_r), 64'd2);
            tick();
            c++;
        end
        start = 1'b0; tap_vld = 1'b0;
        chk({tag, "_done_cycle"}, 64'(c), 64'(6 + stall_len));
        chk({tag, "_done_t"}, 64'(done_t), 64'd1);
        exp_r0 = model(0, 1'b1); exp_r1 = model(1, 1'b1);
        exp_t0 = model(0, 1'b0); exp_t1 = model(1, 1'b0);
        chk({tag, "_out_r"}, 64'(out_r), 64'({exp_r1[15:0], exp_r0[15:0]}));
        chk({tag, "_sat_r"}, 64'(sat_r), 64'({exp_r1[16], exp_r0[16]}));
        chk({tag, "_out_t"}, 64'(out_t), 64'({exp_t1[15:0], exp_t0[15:0]}));
        chk({tag, "_sat_t"}, 64'(sat_t), 64'({exp_t1[16], exp_t0[16]}));
        tick();
        chk({tag, "_done_pulse"}, 64'({done_r, busy_r}), 64'd0);
    endtask

    initial begin
        int c;
        load(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        #12;
        chk("rst_out", 64'({out_r, sat_r, busy_r, done_r, ptr_r}), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_ptr", 64'({ptr_r, busy_r}), 64'd0);

        // Basic
        load(16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h1000, 16'hF000);
        run_pass("basic", 0, 1'b0);
        chk("basic_abs", 64'({out_r, sat_r}), 64'({16'hE000, 16'h2000, 2'b00}));

        // Saturation
        load(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000);
        run_pass("satur", 0, 1'b0);
        chk("satur_abs", 64'({out_r, sat_r}), 64'({16'h8000, 16'h7FFF, 2'b11}));

        // Rounding: single nonzero tap
        load(16'h0001, 16'h0, 16'h0, 16'h0, 16'h4000, 16'h4000);
        run_pass("round", 0, 1'b0);
        chk("round_abs_r", 64'(out_r), 64'h0001_0001);
        chk("round_abs_t", 64'(out_t), 64'h0000_0000);

        // Stall, with an ignored start in the middle
        load(16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h1000, 16'hF000);
        run_pass("stall", 3, 1'b1);
        chk("stall_abs", 64'(out_r), 64'({16'hE000, 16'h2000}));

        // Abort after 2 taps
        load_rand();
        start = 1'b1; tap_vld = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        chk("abort_ptr", 64'(ptr_r), 64'd2);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_idle", 64'({busy_r, ptr_r}), 64'd0);
        for (c = 0; c < 8 && !done_r; c++) tick();
        chk("abort_nodone", 64'(done_r), 64'd0);
        chk("abort_keep", 64'(out_r), 64'({16'hE000, 16'h2000}));

        // Start together with abort in IDLE
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        chk("start_abort", 64'(busy_r), 64'd0);

        // Randomised passes
        for (int i = 0; i < 6; i++) begin
            load_rand();
            run_pass("rand", (i % 2) * (i + 1), 1'b0);
        end

        // Reset mid-pass
        load_rand();
        start = 1'b1; tap_vld = 1'b1; tick(); start = 1'b0;
        tick();
        chk("rst_mid_ptr", 64'(ptr_r), 64'd1);
        #2 rst_n = 1'b0; #1;
        chk("rst_mid_out", 64'({out_r, sat_r, busy_r, done_r, ptr_r}), 64'd0);
        #3 rst_n = 1'b1;
        for (c = 0; c < 10 && !done_r; c++) tick();
        chk("rst_mid_nodone", 64'({done_r, busy_r}), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
